// File: rtl/multi_key_debouncer.sv
// rtl/multi_key_debouncer.sv - N-channel synchroniser, debounce filter, edge pulses and auto-repeat
//
// Purpose:
//   One instance serves every key/switch. Each channel runs identical,
//   independent logic:
//     raw input -> polarity fix -> SYNC_STAGES flop chain -> debounce filter
//     -> press/release pulses -> long-press auto-repeat FSM.
//
// Ports:
//   clock         in   1         system clock
//   reset         in   1         synchronous, active-high reset
//   asyncIn       in   CHANNELS  raw asynchronous button/switch inputs
//   syncOut       out  CHANNELS  debounced level, 1 = pressed
//   pressPulse    out  CHANNELS  1-cycle pulse on debounced 0->1
//   releasePulse  out  CHANNELS  1-cycle pulse on debounced 1->0
//   repeatPulse   out  CHANNELS  1-cycle auto-repeat pulses while held

module multi_key_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] asyncIn,
    output logic [CHANNELS-1:0] syncOut,
    output logic [CHANNELS-1:0] pressPulse,
    output logic [CHANNELS-1:0] releasePulse,
    output logic [CHANNELS-1:0] repeatPulse
);

    // Filter counter only has to reach STABLE_CYCLES-1.
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

    // Hold/repeat counter sized for the longer of the two intervals.
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HCW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    // XOR mask that turns the raw pin into "1 = pressed".
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_d, sync_q;
        logic [CW-1:0]          cnt_d, cnt_q;
        logic                   level_d, level_q;
        logic                   press_d, press_q;
        logic                   release_d, release_q;
        logic                   sample;

        // Chain resets to all-zero, i.e. "not pressed" after the polarity fix.
        assign sample = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d    = {sync_q[SYNC_STAGES-2:0], asyncIn[ch] ^ POL};
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sample == level_q) begin
                // Any agreeing sample restarts the stability window.
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                // This edge is the STABLE_CYCLES-th consecutive differing sample.
                level_d   = sample;
                cnt_d     = '0;
                press_d   = sample;
                release_d = ~sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                sync_q    <= '0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= sync_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign syncOut[ch]      = level_q;
        assign pressPulse[ch]   = press_q;
        assign releasePulse[ch] = release_q;

        if (HOLD_CYCLES > 0) begin : g_rep
            rep_state_e     state_q;
            logic [HCW-1:0] hcount_q;
            logic           rep_q;

            // The FSM reacts to the same-edge rise/fall decisions of the filter,
            // so a release that coincides with a hold/repeat expiry suppresses
            // the repeat pulse, and hold timing starts on the pressPulse edge.
            always_ff @(posedge clock) begin
                if (reset) begin
                    state_q  <= ST_IDLE;
                    hcount_q <= '0;
                    rep_q    <= 1'b0;
                end else begin
                    rep_q <= 1'b0;
                    if (release_d) begin
                        state_q  <= ST_IDLE;
                        hcount_q <= '0;
                    end else begin
                        case (state_q)
                            ST_IDLE: begin
                                if (press_d) begin
                                    state_q  <= ST_HOLD;
                                    hcount_q <= '0;
                                end
                            end
                            ST_HOLD: begin
                                if (hcount_q == HCW'(HOLD_CYCLES - 1)) begin
                                    rep_q    <= 1'b1;
                                    state_q  <= ST_REPEAT;
                                    hcount_q <= '0;
                                end else begin
                                    hcount_q <= hcount_q + HCW'(1);
                                end
                            end
                            ST_REPEAT: begin
                                if (hcount_q == HCW'(REPEAT_CYCLES - 1)) begin
                                    rep_q    <= 1'b1;
                                    hcount_q <= '0;
                                end else begin
                                    hcount_q <= hcount_q + HCW'(1);
                                end
                            end
                            default: begin
                                state_q  <= ST_IDLE;
                                hcount_q <= '0;
                            end
                        endcase
                    end
                end
            end

            assign repeatPulse[ch] = rep_q;
        end else begin : g_no_rep
            assign repeatPulse[ch] = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// tb/tb_multi_key_debouncer.sv - directed self-checking bench for multi_key_debouncer
module tb_multi_key_debouncer;

    logic       clock;
    logic       reset;
    logic [3:0] asyncIn;
    logic [3:0] syncOut;
    logic [3:0] pressPulse;
    logic [3:0] releasePulse;
    logic [3:0] repeatPulse;

    int total;
    int bad;

    multi_key_debouncer #(
        .CHANNELS      (4),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .ACTIVE_LOW    (1),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .asyncIn      (asyncIn),
        .syncOut      (syncOut),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .repeatPulse  (repeatPulse)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        asyncIn = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({syncOut, pressPulse, releasePulse, repeatPulse} !== 16'h0) begin
                bad++;
                $display("FAIL reset_during cyc=%0d got=%h exp=0", i,
                         {syncOut, pressPulse, releasePulse, repeatPulse});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if ({syncOut, pressPulse, releasePulse, repeatPulse} !== 16'h0) begin
                bad++;
                $display("FAIL reset_after cyc=%0d got=%h exp=0", i,
                         {syncOut, pressPulse, releasePulse, repeatPulse});
            end
        end
    endtask

    task automatic test_press_latency();
        asyncIn = 4'hE;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (syncOut !== ((k >= 10) ? 4'h1 : 4'h0)) begin
                bad++;
                $display("FAIL latency_sync k=%0d got=%h exp=%h", k, syncOut,
                         (k >= 10) ? 4'h1 : 4'h0);
            end
            total++;
            if (pressPulse !== ((k == 10) ? 4'h1 : 4'h0)) begin
                bad++;
                $display("FAIL latency_press k=%0d got=%h exp=%h", k, pressPulse,
                         (k == 10) ? 4'h1 : 4'h0);
            end
        end
        asyncIn = 4'hF;
        for (int k = 1; k <= 15; k++) begin
            step();
            total++;
            if (releasePulse !== ((k == 10) ? 4'h1 : 4'h0)) begin
                bad++;
                $display("FAIL latency_release k=%0d got=%h exp=%h", k, releasePulse,
                         (k == 10) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        for (int seg = 0; seg < 10; seg++) begin
            asyncIn[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 3; c++) begin
                step();
                if (pressPulse[1]) presses++;
                total++;
                if (syncOut[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce_hold seg=%0d got=%b exp=0", seg, syncOut[1]);
                end
            end
        end
        asyncIn[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (pressPulse[1]) presses++;
            total++;
            if (syncOut[1] !== (k >= 10)) begin
                bad++;
                $display("FAIL bounce_rise k=%0d got=%b exp=%b", k, syncOut[1], k >= 10);
            end
        end
        total++;
        if (presses != 1) begin
            bad++;
            $display("FAIL bounce_presses got=%0d exp=1", presses);
        end
        total++;
        if (syncOut[0] !== 1'b0 || syncOut[3:2] !== 2'b00) begin
            bad++;
            $display("FAIL bounce_others got=%h exp=2", syncOut);
        end
        asyncIn[1] = 1'b1;
        settle(15);
    endtask

    task automatic test_repeat();
        int reps;
        int rels;
        logic exp_rep;
        reps = 0;
        rels = 0;
        asyncIn[2] = 1'b0;
        settle(10);
        total++;
        if (pressPulse !== 4'h4) begin
            bad++;
            $display("FAIL repeat_press got=%h exp=4", pressPulse);
        end
        // Release applied after offset 59 reaches syncOut at offset 69.
        for (int off = 1; off <= 79; off++) begin
            step();
            exp_rep = (off >= 20) && ((off - 20) % 5 == 0) && (off < 69);
            if (off <= 59 && repeatPulse[2]) reps++;
            if (releasePulse[2]) rels++;
            total++;
            if (repeatPulse[2] !== exp_rep) begin
                bad++;
                $display("FAIL repeat_pulse off=%0d got=%b exp=%b", off, repeatPulse[2], exp_rep);
            end
            total++;
            if (releasePulse[2] !== (off == 69)) begin
                bad++;
                $display("FAIL repeat_release off=%0d got=%b exp=%b", off, releasePulse[2],
                         off == 69);
            end
            if (off == 59) asyncIn[2] = 1'b1;
        end
        total++;
        if (reps != 8) begin
            bad++;
            $display("FAIL repeat_count got=%0d exp=8", reps);
        end
        total++;
        if (rels != 1) begin
            bad++;
            $display("FAIL repeat_release_count got=%0d exp=1", rels);
        end
    endtask

    task automatic test_release_wins();
        asyncIn[2] = 1'b0;
        settle(10);
        total++;
        if (pressPulse[2] !== 1'b1) begin
            bad++;
            $display("FAIL rw_press got=%b exp=1", pressPulse[2]);
        end
        for (int off = 1; off <= 25; off++) begin
            step();
            total++;
            if (repeatPulse[2] !== 1'b0) begin
                bad++;
                $display("FAIL rw_repeat off=%0d got=%b exp=0", off, repeatPulse[2]);
            end
            if (off == 20) begin
                total++;
                if (releasePulse[2] !== 1'b1 || syncOut[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL rw_release got=%b/%b exp=1/0", releasePulse[2], syncOut[2]);
                end
            end
            if (off == 10) asyncIn[2] = 1'b1;
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [3:0] exp_press;
        logic [3:0] exp_sync;
        logic [3:0] exp_rep;
        asyncIn[3] = 1'b0;
        settle(10);
        total++;
        if (pressPulse !== 4'h8) begin
            bad++;
            $display("FAIL mid_press got=%h exp=8", pressPulse);
        end
        for (int off = 1; off <= 22; off++) begin
            step();
            if (off == 20) begin
                total++;
                if (repeatPulse !== 4'h8) begin
                    bad++;
                    $display("FAIL mid_first_repeat got=%h exp=8", repeatPulse);
                end
            end
        end
        reset = 1'b1;
        step();
        total++;
        if ({syncOut, pressPulse, releasePulse, repeatPulse} !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=0",
                     {syncOut, pressPulse, releasePulse, repeatPulse});
        end
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_press = (k == 10) ? 4'h8 : 4'h0;
            exp_sync  = (k >= 10) ? 4'h8 : 4'h0;
            exp_rep   = (k == 30) ? 4'h8 : 4'h0;
            total++;
            if ({syncOut, pressPulse, releasePulse, repeatPulse} !==
                {exp_sync, exp_press, 4'h0, exp_rep}) begin
                bad++;
                $display("FAIL mid_after k=%0d got=%h exp=%h", k,
                         {syncOut, pressPulse, releasePulse, repeatPulse},
                         {exp_sync, exp_press, 4'h0, exp_rep});
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        asyncIn = 4'hF;
        test_reset();
        test_press_latency();
        test_bounce();
        test_repeat();
        settle(15);
        test_release_wins();
        settle(15);
        test_reset_mid_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
